mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous RAM between two requesters: the CPU control path (Read/Write from the control unit via MAR/MDR) and a DMA/input-port loader.
- Sequences each access as grant, then RAM enable, then read-latency wait, then a one-cycle done.
- Registers the read data returned to each requester.
- Sits between the control unit/MDR and the RAM. Stalls the CPU sequencer through cpu_gnt/cpu_done and busy.

Parameters:
ADDR_W, 9, RAM address width
DATA_W, 32, RAM data width
RD_LAT, 2, edges from the RAM sampling ram_en until ram_rdata is valid; legal range 1..8

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request; held until cpu_done
cpu_we  input  1  1=write, 0=read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  CPU owns the RAM
cpu_done  output  1  one-cycle completion pulse
cpu_rdata  output  DATA_W  last CPU read data
dma_req  input  1  DMA access request
dma_we  input  1  DMA write enable
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  DATA_W  DMA write data
dma_gnt  output  1  DMA owns the RAM
dma_done  output  1  one-cycle completion pulse
dma_rdata  output  DATA_W  last DMA read data
ram_en  output  1  RAM access strobe
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data
busy  output  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, Clock. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: every output 0, including rdata registers. State=IDLE, lat_cnt=0, last_owner=DMA.
- States and transitions:
  - IDLE: at edge E0, with any req high, pick owner.
    - Latch that requester's we/addr/wdata into ram_we/ram_addr/ram_wdata.
    - Set ram_en=1, owner gnt=1, go to ACCESS.
  - ACCESS: exactly one cycle with ram_en=1. At E1, ram_en falls.
    - Write: go to DONE, setting owner done=1 and gnt=0 at E1.
    - Read: load lat_cnt=RD_LAT-1 and go to WAIT.
  - WAIT: lat_cnt decrements each edge. At edge E(1+RD_LAT):
    - Capture ram_rdata into the owner's rdata register.
    - Set done=1, gnt=0, go to DONE.
  - DONE: done high exactly one cycle. The next edge clears done, updates last_owner=owner and goes to IDLE.
- Latency:
  - Write: done rises 1 edge after the grant edge.
  - Read: done rises 1+RD_LAT edges after the grant edge.
  - At least one IDLE cycle separates consecutive transactions.
- Handshake:
  - A requester holds req and its fields stable until it samples done=1, then drops req.
  - A req still high in IDLE is treated as a new request.
  - Fields are latched at grant, so dropping req after grant does not abort the access.
  - Dropping req before grant means no access occurs.
- Arbitration:
  - A single request is granted directly.
  - Simultaneous requests use round-robin: grant the requester that is not last_owner. The first tie after reset goes to the CPU.
  - Requests arriving while busy wait; there is no preemption.
- ram_addr, ram_wdata and ram_we hold their values outside ACCESS. The RAM must qualify them with ram_en.
- rdata registers change only on a read completing for that requester. Writes never alter them.
- Reset mid-operation (any state): outputs clear immediately and asynchronously. No done is produced and the transaction is lost; the requester reissues.
- cpu_gnt and dma_gnt are never both 1. Likewise cpu_done and dma_done are never both 1.

Optional Feature:
- Macro: ARB_CPU_PRIORITY_EN.
- Defined: ties always go to the CPU; last_owner is ignored. The DMA waits until cpu_req is low in IDLE.
- Undefined: round-robin as above.

Test Plan:
1. Assert Reset mid-idle with random inputs -> all outputs 0, busy=0; after release, first tie goes to CPU.
2. RD_LAT=2, CPU write addr 0x010 data 0xDEADBEEF -> ram_en=1 for one cycle with ram_we=1, ram_addr=0x010, ram_wdata=0xDEADBEEF. cpu_done is high one cycle from E1. cpu_rdata stays 0.
3. CPU read addr 0x010, RAM model (RD_LAT=2) returns 0xDEADBEEF -> cpu_done rises at E3 for one cycle, cpu_rdata=0xDEADBEEF, ram_we=0 during ACCESS.
4. cpu_req and dma_req held high together for 4 transactions -> grant order CPU, DMA, CPU, DMA. With ARB_CPU_PRIORITY_EN: CPU ×4, DMA never granted.
5. DMA read of 0x1FF issued while a CPU read is in WAIT -> dma_gnt stays 0 until after the cpu_done cycle, busy stays 1 throughout. dma_rdata receives the 0x1FF data; cpu_rdata is unchanged.
6. Reset pulsed during WAIT of a DMA read -> ram_en, dma_gnt and busy are 0 immediately, and no dma_done appears. A reissued request completes normally with correct data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / DMA) arbiter and access sequencer for a single-port synchronous RAM.
// Optional build macro ARB_CPU_PRIORITY_EN: ties go to the CPU instead of round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int LAT_W = 3;

  logic [1:0]       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             owner;
  logic             last_owner;
  logic             pick_dma;

  always_comb begin
    pick_dma = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
    pick_dma = dma_req && !cpu_req;
`else
    // On a tie, the requester that did not win last time goes next.
    pick_dma = dma_req && (!cpu_req || (last_owner == OWN_CPU));
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      owner      <= OWN_DMA;
      last_owner <= OWN_DMA;
      cpu_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      dma_gnt    <= 1'b0;
      dma_done   <= 1'b0;
      dma_rdata  <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || dma_req) begin
            owner  <= pick_dma;
            ram_en <= 1'b1;
            busy   <= 1'b1;
            state  <= S_ACCESS;
            if (pick_dma) begin
              dma_gnt   <= 1'b1;
              ram_we    <= dma_we;
              ram_addr  <= dma_addr;
              ram_wdata <= dma_wdata;
            end else begin
              cpu_gnt   <= 1'b1;
              ram_we    <= cpu_we;
              ram_addr  <= cpu_addr;
              ram_wdata <= cpu_wdata;
            end
          end
        end
        S_ACCESS: begin
          ram_en <= 1'b0;
          if (ram_we) begin
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            cpu_done <= (owner == OWN_CPU);
            dma_done <= (owner == OWN_DMA);
            state    <= S_DONE;
          end else begin
            lat_cnt <= LAT_W'(RD_LAT - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            if (owner == OWN_DMA) dma_rdata <= ram_rdata;
            else                  cpu_rdata <= ram_rdata;
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            cpu_done <= (owner == OWN_CPU);
            dma_done <= (owner == OWN_DMA);
            state    <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_DONE: begin
          cpu_done   <= 1'b0;
          dma_done   <= 1'b0;
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
